// File: rtl/vpu_exec_issue_ctrl.sv
// vpu_exec_issue_ctrl: issue-side controller for one VPU exec lane.
// Accepts one operation at a time and drives the exec unit with held inputs.
// It waits for the done pulse, or times out, then returns a tagged response.
module vpu_exec_issue_ctrl #(
  parameter int DWIDTH_PER_EXEC = 256,
  parameter int SRC_OPERAND_CNT = 3,
  parameter int OP_WIDTH        = 8,
  parameter int MAX_DELAY_LG2   = 5,
  parameter int TAG_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        req_valid_i,
  output logic                                        req_ready_o,
  input  logic [OP_WIDTH-1:0]                         req_op_i,
  input  logic [MAX_DELAY_LG2-1:0]                    req_delay_i,
  input  logic [SRC_OPERAND_CNT*DWIDTH_PER_EXEC-1:0]  req_operand_i,
  input  logic [SRC_OPERAND_CNT-1:0]                  req_operand_valid_i,
  input  logic [TAG_WIDTH-1:0]                        req_tag_i,
  output logic                                        exec_start_o,
  output logic [OP_WIDTH-1:0]                         exec_op_o,
  output logic [MAX_DELAY_LG2-1:0]                    exec_delay_o,
  output logic [SRC_OPERAND_CNT*DWIDTH_PER_EXEC-1:0]  exec_operand_o,
  output logic [SRC_OPERAND_CNT-1:0]                  exec_operand_valid_o,
  input  logic [DWIDTH_PER_EXEC-1:0]                  exec_dout_i,
  input  logic                                        exec_done_i,
  output logic                                        rsp_valid_o,
  input  logic                                        rsp_ready_i,
  output logic [DWIDTH_PER_EXEC-1:0]                  rsp_data_o,
  output logic [TAG_WIDTH-1:0]                        rsp_tag_o,
  output logic                                        rsp_err_o,
  output logic                                        busy_o,
  output logic                                        spurious_o
);

  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);
  localparam int OPND_W = SRC_OPERAND_CNT * DWIDTH_PER_EXEC;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [OP_WIDTH-1:0]          op_q, op_d;
  logic [MAX_DELAY_LG2-1:0]     delay_q, delay_d;
  logic [OPND_W-1:0]            operand_q, operand_d;
  logic [SRC_OPERAND_CNT-1:0]   operand_valid_q, operand_valid_d;
  logic [TAG_WIDTH-1:0]         tag_q, tag_d;
  logic                         start_q, start_d;
  logic                         rsp_valid_q, rsp_valid_d;
  logic [DWIDTH_PER_EXEC-1:0]   rsp_data_q, rsp_data_d;
  logic                         rsp_err_q, rsp_err_d;
  logic                         spurious_q, spurious_d;

  // Ready and busy are decoded straight from the state so a new request can land the cycle after a response handshake.
  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);

  // Next-state logic: the request fields are latched once on acceptance and stay put until the next acceptance, so the exec unit's op mux never moves mid-operation.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    op_d            = op_q;
    delay_d         = delay_q;
    operand_d       = operand_q;
    operand_valid_d = operand_valid_q;
    tag_d           = tag_q;
    start_d         = 1'b0;
    rsp_valid_d     = rsp_valid_q;
    rsp_data_d      = rsp_data_q;
    rsp_err_d       = rsp_err_q;
    spurious_d      = 1'b0;
    case (state_q)
      IDLE: begin
        spurious_d = exec_done_i;
        if (req_valid_i && req_ready_o) begin
          op_d            = req_op_i;
          delay_d         = req_delay_i;
          operand_d       = req_operand_i;
          operand_valid_d = req_operand_valid_i;
          tag_d           = req_tag_i;
          start_d         = 1'b1;
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        spurious_d = exec_done_i;
        cnt_d      = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (exec_done_i) begin
          rsp_data_d  = exec_dout_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        spurious_d = exec_done_i;
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any operation in flight without producing a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      op_q            <= '0;
      delay_q         <= '0;
      operand_q       <= '0;
      operand_valid_q <= '0;
      tag_q           <= '0;
      start_q         <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      rsp_err_q       <= 1'b0;
      spurious_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      op_q            <= op_d;
      delay_q         <= delay_d;
      operand_q       <= operand_d;
      operand_valid_q <= operand_valid_d;
      tag_q           <= tag_d;
      start_q         <= start_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      rsp_err_q       <= rsp_err_d;
      spurious_q      <= spurious_d;
    end
  end

  assign exec_start_o         = start_q;
  assign exec_op_o            = op_q;
  assign exec_delay_o         = delay_q;
  assign exec_operand_o       = operand_q;
  assign exec_operand_valid_o = operand_valid_q;
  assign rsp_valid_o          = rsp_valid_q;
  assign rsp_data_o           = rsp_data_q;
  assign rsp_tag_o            = tag_q;
  assign rsp_err_o            = rsp_err_q;
  assign spurious_o           = spurious_q;

endmodule

// File: doc/vpu_exec_issue_ctrl.md
# vpu_exec_issue_ctrl

Issue-side controller for the VPU execution unit. It accepts one vector operation at a time over a valid/ready request port and drives the exec unit's start/op/delay/operand inputs. It holds those inputs stable until the exec unit's one-cycle done pulse, captures the result, and returns it with its tag over a valid/ready response port. A watchdog converts a missing done into an error response, so a hung lane cannot stall the dispatcher.

## Interface
Parameters:
- DWIDTH_PER_EXEC, 256: result and per-operand data width
- SRC_OPERAND_CNT, 3: number of source operands
- OP_WIDTH, 8: width of the packed op_func word (VPU_PKG::vpu_exec_req_t)
- MAX_DELAY_LG2, 5: width of the delay field
- TAG_WIDTH, 4: request tag width
- TIMEOUT_CYCLES, 64: WAIT cycles allowed before timeout; must be ≥ 2

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk, in, 1: clock
- rst, in, 1: synchronous active-high reset
- req_valid_i, in, 1: request valid
- req_ready_o, out, 1: request ready
- req_op_i, in, OP_WIDTH: op_func
- req_delay_i, in, MAX_DELAY_LG2: exec delay
- req_operand_i, in, SRC_OPERAND_CNT×DWIDTH_PER_EXEC: operands, operand k at [k*DWIDTH+:DWIDTH]
- req_operand_valid_i, in, SRC_OPERAND_CNT: per-operand valid
- req_tag_i, in, TAG_WIDTH: tag
- exec_start_o, out, 1: start pulse to exec unit
- exec_op_o, out, OP_WIDTH: op_func to exec unit
- exec_delay_o, out, MAX_DELAY_LG2: delay to exec unit
- exec_operand_o, out, SRC_OPERAND_CNT×DWIDTH_PER_EXEC: operands to exec unit
- exec_operand_valid_o, out, SRC_OPERAND_CNT: operand valids to exec unit
- exec_dout_i, in, DWIDTH_PER_EXEC: exec result, meaningful only when exec_done_i is 1
- exec_done_i, in, 1: exec done pulse
- rsp_valid_o, out, 1: response valid
- rsp_ready_i, in, 1: response ready
- rsp_data_o, out, DWIDTH_PER_EXEC: result
- rsp_tag_o, out, TAG_WIDTH: echoed tag
- rsp_err_o, out, 1: 1 means timeout
- busy_o, out, 1: state ≠ IDLE
- spurious_o, out, 1: one-cycle pulse when exec_done_i arrives outside WAIT

## Operation
State machine: IDLE → ISSUE → WAIT → RESP → IDLE.

- **IDLE**
  - req_ready_o = 1.
  - On req_valid_i & req_ready_o: register op, delay, operands, operand_valid and tag; go to ISSUE.
- **ISSUE** (exactly one cycle)
  - exec_start_o = 1; go to WAIT.
  - Clear the timeout counter.
- **WAIT**
  - exec_op_o, exec_delay_o, exec_operand_o and exec_operand_valid_o hold the registered values through the entire operation, ISSUE through RESP. The exec unit muxes its output on op_func, so these must not change.
  - exec_done_i = 1: capture exec_dout_i into rsp_data, set err = 0, go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES−1 without done: rsp_data = 0, err = 1, go to RESP.
  - Done and timeout in the same cycle: done wins (err = 0, data captured).
- **RESP**
  - rsp_valid_o = 1. rsp_data_o, rsp_tag_o and rsp_err_o are stable until rsp_ready_i.
  - On handshake: go to IDLE.
  - exec_done_i here (a late done after a timeout) is dropped and pulses spurious_o.
- **Stray done:** exec_done_i in IDLE or ISSUE is ignored and pulses spurious_o the next cycle.
- **Operand valids:** no checking. All-zero valids are issued unchanged.
- **Counter:** width $clog2(TIMEOUT_CYCLES); no wrap, because it is cleared in ISSUE.

## Timing
- **Reset values:** every output is 0 (exec_* buses, rsp_* buses, exec_start_o, rsp_valid_o, busy_o, spurious_o), except req_ready_o = 1 (IDLE). State = IDLE; counter and data registers = 0.
- **Reset mid-operation:** abandon the operation and return to IDLE; no response is produced; exec_start_o is not reasserted.
- **Issue latency:** request handshake at cycle T → exec_start_o high at T+1 only → WAIT from T+2.
- **Result capture:** done in cycle D → rsp_valid_o from D+1, with data equal to exec_dout_i sampled at D.
- **Minimum turnaround:** done at T+2 gives response at T+3. With rsp_ready_i = 1 the next request can be accepted at T+4.
- **Timeout:** with no done, rsp_valid_o (err = 1) rises at T+2+TIMEOUT_CYCLES.
- **Throughput:** at most one operation in flight; req_ready_o = 0 from T+1 until the cycle after the response handshake.
- **Outputs:** all outputs are registered except req_ready_o and busy_o, which are decoded from the state register.

## Test plan
- **Basic op:** tag = 3, op = 0x01, delay = 4, operand0 = 0xA5 repeated; exec model asserts done at T+6 with dout = 0x1234 → exactly one exec_start_o pulse at T+1; exec_op_o is stable T+1…T+7; response at T+7 with data = 0x1234, tag = 3, err = 0.
- **Backpressure:** rsp_ready_i held low for 10 cycles after rsp_valid_o → data, tag and err are unchanged; req_ready_o = 0 throughout; returns to IDLE the cycle after ready rises.
- **Timeout:** TIMEOUT_CYCLES = 8, the model never asserts done → rsp_valid_o at T+10 with err = 1, data = 0. A done injected later, in RESP → spurious_o pulses once and the response is unchanged.
- **Done/timeout race:** done asserted on the same cycle the counter reaches TIMEOUT_CYCLES−1 → err = 0 and the captured data is returned.
- **Reset mid-WAIT:** rst pulsed 2 cycles after start → all outputs 0, req_ready_o = 1 next cycle; a subsequent request (tag = 5) completes normally with tag = 5.
- **Back-to-back:** 4 requests with tags 0–3 and rsp_ready_i tied high → responses come back in order with tags 0–3; exactly 4 start pulses; each request is accepted 1 cycle after the previous response handshake.
